edge_event_arbiter: RTL

//  Watches N active-high level inputs. Detects both edges on each one.

---
 rtl/edge_event_arbiter_pkg.sv | 28 ++
 rtl/edge_event_arbiter_if.sv | 12 +
 rtl/edge_event_arbiter_chan.sv | 65 ++++++
 rtl/edge_event_arbiter.sv | 82 ++++++++
 4 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// edge_event_arbiter_pkg: FSM state encoding and round-robin pick helper shared by the arbiter
package edge_event_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // First set pend bit at or after rr+1 (mod n); returns rr when nothing is pending
    function automatic int rr_pick(input logic [15:0] pend, input int rr, input int n);
        int r;
        int idx;
        logic found;
        r = rr;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= n && !found) begin
                idx = (rr + k) % n;
                if (pend[idx]) begin
                    r = idx;
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// edge_event_arbiter_if: valid/ready event port carrying channel id and edge polarity
interface edge_event_arbiter_if #(
    parameter int IDW = 2
);
    logic           ev_valid;
    logic           ev_ready;
    logic [IDW-1:0] ev_id;
    logic           ev_rise;

    modport master (output ev_valid, output ev_id, output ev_rise, input ev_ready);
    modport slave  (input ev_valid, input ev_id, input ev_rise, output ev_ready);
endinterface

// File: rtl/edge_event_arbiter_chan.sv
// edge_event_arbiter_chan: per-channel edge detector with one-deep pending slot and sticky overrun
// Optional EDGE_ARB_SYNC_EN adds a 2-flop synchroniser ahead of the edge detector.
module edge_event_arbiter_chan (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    input  logic i_take,
    input  logic i_clr_overrun,
    output logic o_pend,
    output logic o_pol,
    output logic o_overrun
);
    logic w_lvl;
    logic w_edge;
    logic r_lvl_q;
    logic r_pend;
    logic r_pol;
    logic r_overrun;

`ifdef EDGE_ARB_SYNC_EN
    logic [1:0] r_sync;

    // Two-stage synchroniser for an asynchronous level
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], i_level};
    end

    assign w_lvl = r_sync[1];
`else
    assign w_lvl = i_level;
`endif

    // Previous level, compared against the current one to find either edge
    always_ff @(posedge clk) begin
        if (rst) r_lvl_q <= 1'b0;
        else     r_lvl_q <= w_lvl;
    end

    assign w_edge = w_lvl ^ r_lvl_q;

    // A free (or just-vacated) slot captures the edge; a taken slot with no new edge empties
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_pol  <= 1'b0;
        end else if (w_edge && (!r_pend || i_take)) begin
            r_pend <= 1'b1;
            r_pol  <= w_lvl;
        end else if (i_take) begin
            r_pend <= 1'b0;
        end
    end

    // Edge hitting an occupied slot is dropped and flagged; flagging beats clearing
    always_ff @(posedge clk) begin
        if (rst)                               r_overrun <= 1'b0;
        else if (w_edge && r_pend && !i_take)  r_overrun <= 1'b1;
        else if (i_clr_overrun)                r_overrun <= 1'b0;
    end

    assign o_pend    = r_pend;
    assign o_pol     = r_pol;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: serialises per-channel level edges onto one valid/ready port in round-robin order
// Build option EDGE_ARB_SYNC_EN inserts a 2-flop synchroniser per channel (+2 cycles latency).
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_level,
    input  logic [N-1:0]         i_clr_overrun,
    output logic [N-1:0]         o_pend,
    output logic [N-1:0]         o_overrun,
    edge_event_arbiter_if.master ev
);
    state_t         r_state;
    state_t         w_next;
    logic           w_load;
    logic           w_any;
    logic [IDW-1:0] w_win;
    logic [N-1:0]   w_take;
    logic [N-1:0]   w_pend;
    logic [N-1:0]   w_pol;
    logic [IDW-1:0] r_rr;
    logic [IDW-1:0] r_id;
    logic           r_rise;

    for (genvar g = 0; g < N; g++) begin : g_chan
        edge_event_arbiter_chan u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_level      (i_level[g]),
            .i_take       (w_take[g]),
            .i_clr_overrun(i_clr_overrun[g]),
            .o_pend       (w_pend[g]),
            .o_pol        (w_pol[g]),
            .o_overrun    (o_overrun[g])
        );
    end

    assign w_any  = |w_pend;
    assign w_win  = IDW'(rr_pick(16'(w_pend), int'(r_rr), N));
    assign w_take = w_load ? ({{(N-1){1'b0}}, 1'b1} << w_win) : '0;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state and load strobe: load from IDLE on any pending, or on accept while more are pending
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        if (r_state == ST_IDLE) begin
            w_load = w_any;
            w_next = w_any ? ST_OFFER : ST_IDLE;
        end else begin
            w_load = ev.ev_ready && w_any;
            w_next = (ev.ev_ready && !w_any) ? ST_IDLE : ST_OFFER;
        end
    end

    // Output event register and round-robin pointer advance on every grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id   <= '0;
            r_rise <= 1'b0;
            r_rr   <= '0;
        end else if (w_load) begin
            r_id   <= w_win;
            r_rise <= w_pol[w_win];
            r_rr   <= w_win;
        end
    end

    assign ev.ev_valid = (r_state == ST_OFFER);
    assign ev.ev_id    = r_id;
    assign ev.ev_rise  = r_rise;
    assign o_pend      = w_pend;
endmodule
